// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that shares one 16-bit hex display among N_REQ requesters.
// A granted requester keeps the display for HOLD_CYCLES cycles; force_en overrides arbitration.
module hex_display_arbiter #(
  parameter int N_REQ = 4,
  parameter int HOLD_CYCLES = 50000000,
  localparam int OW = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_data,
  input  logic                  force_en,
  input  logic [OW-1:0]         force_sel,
  output logic [N_REQ-1:0]      grant,
  output logic [OW-1:0]         disp_owner,
  output logic                  disp_valid,
  output logic [15:0]           disp_data
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [OW:0]      N_REQ_W   = (OW+1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN, FORCE} state_t;

  state_t             state_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [OW-1:0]      owner_reg;
  logic               valid_reg;
  logic [15:0]        data_reg;
  logic [CW-1:0]      count_reg;
  logic [OW-1:0]      last_reg;

  logic [15:0]        data_arr [N_REQ];
  logic [OW-1:0]      force_idx;
  logic [OW-1:0]      pick_all;
  logic [OW-1:0]      pick_other;
  logic [N_REQ-1:0]   other;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[16*gi +: 16];
    end
  endgenerate

  // First set bit of mask, scanning upward from the requester after last.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                            input logic [OW-1:0] last);
    logic [OW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && mask[idx]) begin
        win   = OW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign force_idx  = ({1'b0, force_sel} < N_REQ_W) ? force_sel : '0;
  assign other      = req & ~grant_reg;
  assign pick_all   = rr_pick(req, last_reg);
  assign pick_other = rr_pick(other, last_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
      last_reg  <= OW'(N_REQ - 1);
    end else if (force_en) begin
      // Forcing never advances the round-robin pointer.
      state_reg <= FORCE;
      grant_reg <= ONE << force_idx;
      owner_reg <= force_idx;
      valid_reg <= 1'b1;
      data_reg  <= data_arr[force_idx];
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg <= HOLD;
            grant_reg <= ONE << pick_all;
            owner_reg <= pick_all;
            valid_reg <= 1'b1;
            data_reg  <= data_arr[pick_all];
            count_reg <= HOLD_LOAD;
            last_reg  <= pick_all;
          end
        end
        HOLD: begin
          if (req[owner_reg]) data_reg <= data_arr[owner_reg];
          if (count_reg == '0) state_reg <= OPEN;
          else                 count_reg <= count_reg - CW'(1);
        end
        OPEN: begin
          if (|other) begin
            state_reg <= HOLD;
            grant_reg <= ONE << pick_other;
            owner_reg <= pick_other;
            valid_reg <= 1'b1;
            data_reg  <= data_arr[pick_other];
            count_reg <= HOLD_LOAD;
            last_reg  <= pick_other;
          end else if (req[owner_reg]) begin
            data_reg <= data_arr[owner_reg];
          end else begin
            state_reg <= IDLE;
            grant_reg <= '0;
            valid_reg <= 1'b0;
          end
        end
        FORCE: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          valid_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant      = grant_reg;
  assign disp_owner = owner_reg;
  assign disp_valid = valid_reg;
  assign disp_data  = data_reg;

endmodule
